// File: rtl/confreg_bus_arb.sv
// ============================================================================
// Module   : confreg_bus_arb
// Brief    : Two-master arbiter for the config-register port with a
//            fixed-latency response tag pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module confreg_bus_arb #(
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int RR_EN  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [3:0]    m0_wen,
  input  logic [DW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [3:0]    m1_wen,
  input  logic [DW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          conf_en,
  output logic [3:0]    conf_wen,
  output logic [DW-1:0] conf_addr,
  output logic [DW-1:0] conf_wdata,
  input  logic [DW-1:0] conf_rdata
);

  logic              prefer_m1;
  logic [RD_LAT-1:0] tag_valid;
  logic [RD_LAT-1:0] tag_owner;
  logic [RD_LAT-1:0] tag_write;
  logic              exit_valid;
  logic              exit_owner;
  logic              exit_write;

  // Grants are gated by reset so every output drops as soon as reset asserts.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset) begin
      if (m0_req && m1_req) begin
        if ((RR_EN != 0) && prefer_m1) m1_gnt = 1'b1;
        else                           m0_gnt = 1'b1;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    conf_en    = m0_gnt | m1_gnt;
    conf_wen   = 4'h0;
    conf_addr  = '0;
    conf_wdata = '0;
    if (m0_gnt) begin
      conf_wen   = m0_wen;
      conf_addr  = m0_addr;
      conf_wdata = m0_wdata;
    end else if (m1_gnt) begin
      conf_wen   = m1_wen;
      conf_addr  = m1_addr;
      conf_wdata = m1_wdata;
    end
  end

  // Owner bit: 1 = m1. Stage 0 is loaded in the grant cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prefer_m1 <= 1'b0;
      tag_valid <= '0;
      tag_owner <= '0;
      tag_write <= '0;
    end else begin
      if (conf_en) prefer_m1 <= m0_gnt;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
        tag_write[i] <= tag_write[i-1];
      end
      tag_valid[0] <= conf_en;
      tag_owner[0] <= m1_gnt;
      tag_write[0] <= (conf_wen != 4'h0);
    end
  end

  assign exit_valid = tag_valid[RD_LAT-1];
  assign exit_owner = tag_owner[RD_LAT-1];
  assign exit_write = tag_write[RD_LAT-1];

  assign m0_rvalid = exit_valid && !exit_owner;
  assign m1_rvalid = exit_valid &&  exit_owner;
  assign m0_rdata  = (m0_rvalid && !exit_write) ? conf_rdata : '0;
  assign m1_rdata  = (m1_rvalid && !exit_write) ? conf_rdata : '0;

endmodule

`default_nettype wire
